// File: rtl/n_pg_stage.sv
// Registered bit-level inverted propagate/generate stage for the Knowles prefix adder.
// Define N_PG_SKID_EN to add a second (skid) entry and a registered in_ready.
module n_pg_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] n_P,
    output logic [WIDTH-1:0] n_G,
    output logic [WIDTH-1:0] hs
);

    logic [WIDTH-1:0] pg_n_p;
    logic [WIDTH-1:0] pg_n_g;
    logic [WIDTH-1:0] pg_hs;
    logic             in_xfer;
    logic             out_xfer;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        pg_hs     = a ^ b;
        pg_n_p    = ~pg_hs;
        pg_n_g    = ~(a & b);
        // Bit 0 carries cin as generate, so its propagate is forced to 0.
        pg_n_p[0] = 1'b1;
        pg_n_g[0] = ~((a[0] & b[0]) | (pg_hs[0] & cin));
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

`ifdef N_PG_SKID_EN

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             in_ready_q;
    logic             load_in;
    logic             load_skid;
    logic             promote;
    logic [WIDTH-1:0] skid_n_p;
    logic [WIDTH-1:0] skid_n_g;
    logic [WIDTH-1:0] skid_hs;

    always_comb begin
        state_nxt = state;
        load_in   = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_xfer) begin
                    load_in   = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    load_in = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_nxt = ST_TWO;
                end else if (out_xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    promote   = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != ST_TWO);
        end
    end

    // NOTE: the data registers are reset too, because their cleared value (P=0, G=0) is observable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            skid_n_p <= '1;
            skid_n_g <= '1;
            skid_hs  <= '0;
            n_P      <= '1;
            n_G      <= '1;
            hs       <= '0;
        end else begin
            if (load_skid) begin
                skid_n_p <= pg_n_p;
                skid_n_g <= pg_n_g;
                skid_hs  <= pg_hs;
            end
            if (load_in) begin
                n_P <= pg_n_p;
                n_G <= pg_n_g;
                hs  <= pg_hs;
            end else if (promote) begin
                n_P <= skid_n_p;
                n_G <= skid_n_g;
                hs  <= skid_hs;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != ST_EMPTY);

`else

    // Holds in_ready low until the first edge after reset release.
    logic armed;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            armed     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (in_xfer) begin
                out_valid <= 1'b1;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            n_P <= '1;
            n_G <= '1;
            hs  <= '0;
        end else if (in_xfer) begin
            n_P <= pg_n_p;
            n_G <= pg_n_g;
            hs  <= pg_hs;
        end
    end

    assign in_ready = armed & (~out_valid | out_ready);

`endif

endmodule

// File: tb/tb_n_pg_stage.sv
// Self-checking bench for n_pg_stage: transaction-queue model checked every cycle,
// plus directed literal checks for reset, basic transfer, carry fold and backpressure.
module tb_n_pg_stage;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
    } op_t;

    logic         clk;
    logic         n_rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] n_P;
    logic [W-1:0] n_G;
    logic [W-1:0] hs;

    n_pg_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_P       (n_P),
        .n_G       (n_G),
        .hs        (hs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  popped = 0;
    int  sent = 0;
    op_t q[$];
    bit  armed = 0;
    bit  ix = 0;
    bit  ox = 0;
    op_t smp;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected vectors from the arithmetic meaning of each bit.
    function automatic logic [W-1:0] exp_hs(input op_t o);
        return o.a ^ o.b;
    endfunction

    function automatic logic [W-1:0] exp_np(input op_t o);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = (i == 0) ? 1'b1 : !(o.a[i] != o.b[i]);
        return r;
    endfunction

    function automatic logic [W-1:0] exp_ng(input op_t o);
        logic [W-1:0] r;
        int s0;
        for (int i = 1; i < W; i++) r[i] = !(o.a[i] && o.b[i]);
        s0 = int'(o.a[0]) + int'(o.b[0]) + int'(o.cin);
        r[0] = !(s0 >= 2);
        return r;
    endfunction

    // Ripple reconstruction of the sum from the registered vectors.
    function automatic logic [W-1:0] sum_from_pg(input logic [W-1:0] np, input logic [W-1:0] ng,
                                                 input logic [W-1:0] h, input logic c);
        logic [W-1:0] s;
        logic carry;
        s[0]  = h[0] ^ c;
        carry = ~ng[0];
        for (int i = 1; i < W; i++) begin
            s[i]  = h[i] ^ carry;
            carry = ~ng[i] | (~np[i] & carry);
        end
        return s;
    endfunction

    always @(negedge clk) begin
        logic exp_rdy;
        ix = 0;
        ox = 0;
        if (n_rst) begin
`ifdef N_PG_SKID_EN
            exp_rdy = armed && (q.size() < 2);
`else
            exp_rdy = armed && ((q.size() == 0) || out_ready);
`endif
            check("mon out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
            check("mon in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            if (q.size() > 0) begin
                check("mon n_P", n_P, exp_np(q[0]));
                check("mon n_G", n_G, exp_ng(q[0]));
                check("mon hs", hs, exp_hs(q[0]));
                check("mon sum", sum_from_pg(n_P, n_G, hs, q[0].cin), q[0].a + q[0].b + W'(q[0].cin));
            end
            ix    = in_valid && in_ready;
            ox    = out_valid && out_ready;
            smp.a = a;
            smp.b = b;
            smp.cin = cin;
        end
    end

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q.delete();
            armed = 0;
        end else begin
            if (ox && q.size() > 0) begin
                void'(q.pop_front());
                popped++;
            end
            if (ix) q.push_back(smp);
            armed = 1;
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        bit got;
        got = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (got) sent++;
        else check("send timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc;
        int t0;
        int p0;
        int s0;
        bit done;
        op_t x;

        n_rst = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd0);
        check("reset n_P", n_P, 32'hFFFF_FFFF);
        check("reset n_G", n_G, 32'hFFFF_FFFF);
        check("reset hs", hs, 32'h0);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("release in_ready", {31'b0, in_ready}, 32'd1);

        // Basic transfer
        out_ready = 1'b1;
        send(32'h0000_000F, 32'h0000_0001, 1'b0);
        check("basic hs", hs, 32'h0000_000E);
        check("basic n_G", n_G, 32'hFFFF_FFFE);
        check("basic n_P", n_P, 32'hFFFF_FFF1);
        check("basic out_valid", {31'b0, out_valid}, 32'd1);

        // Carry-in fold into bit 0
        send(32'h0000_0001, 32'h0000_0000, 1'b1);
        check("cin1 n_G0", {31'b0, n_G[0]}, 32'd0);
        check("cin1 hs0", {31'b0, hs[0]}, 32'd1);
        send(32'h0000_0001, 32'h0000_0000, 1'b0);
        check("cin0 n_G0", {31'b0, n_G[0]}, 32'd1);
        check("cin0 hs0", {31'b0, hs[0]}, 32'd1);
        drain();

        // Backpressure
        out_ready = 1'b0;
        x.a = 32'hA5A5_0F0F;
        x.b = 32'h1234_5678;
        x.cin = 1'b1;
        send(x.a, x.b, x.cin);
        in_valid = 1'b1;
        a = 32'h0BAD_CAFE;
        b = 32'h7777_0001;
        cin = 1'b0;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        check("bp hs held", hs, 32'hB791_5977);
        check("bp n_G held", n_G, exp_ng(x));
        check("bp in_ready", {31'b0, in_ready}, 32'd0);
`ifdef N_PG_SKID_EN
        check("bp accepted", acc, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
`else
        check("bp accepted", acc, 32'd0);
        out_ready = 1'b1;
        send(32'h0BAD_CAFE, 32'h7777_0001, 1'b0);
`endif
        drain();

        // Reset mid-transfer with out_valid high
        out_ready = 1'b0;
        send($urandom, $urandom, 1'b1);
        #3;
        n_rst = 1'b0;
        #1;
        check("midrst out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst in_ready", {31'b0, in_ready}, 32'd0);
        check("midrst n_P", n_P, 32'hFFFF_FFFF);
        check("midrst n_G", n_G, 32'hFFFF_FFFF);
        check("midrst hs", hs, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Streaming: one accepted per cycle
        out_ready = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
        check("stream cycles", cyc - t0, 32'd100);
        drain();

        // Random ready/valid
        p0 = popped;
        s0 = sent;
        done = 0;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    send($urandom, $urandom, 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                done = 1;
            end
            begin
                for (int i = 0; i < 3000 && !done; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("random sent", sent - s0, 32'd250);
        check("random popped", popped - p0, 32'd250);
        check("random empty", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
